display_scanner: RTL and testbench
==================================

# display_scanner

Time-multiplexed driver for a DIGITS-wide seven-segment display that shares a single `seven_segment` decoder among all digits. It sits between the value-producing logic and the board's anode and segment pins. Each digit is enabled in turn for a fixed dwell, with a short all-off blanking gap between digits to suppress ghosting. New display words are double-buffered, so a frame never shows a mix of old and new digits.

## Interface
- `DIGITS`, 4: number of digits scanned; must be at least 2.
- `REFRESH_DIV`, 50000: clock cycles each digit is lit; must be at least 1.
- `BLANK_CYCLES`, 1000: clock cycles with all anodes off between digits; must be at least 1.
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: scanning enabled when high.
- `load` input 1: one-cycle strobe that captures `value_in`.
- `value_in` input 4*DIGITS: packed nibbles; digit d uses bits [4d+3:4d], and digit 0 is rightmost.
- `digit_sel_n` output DIGITS: active-low one-hot anode select; all ones means dark.
- `segments` output 7: segment pattern, same bit order and encoding as `seven_segment`.
- `frame_start` output 1: one-cycle pulse when digit 0 becomes lit.
- `load_ack` output 1: one-cycle pulse when a pending word is committed to the display.

## Operation
- Registers:
  - `pending` (4*DIGITS) and `pend_valid` (1).
  - `shown` (4*DIGITS).
  - `idx` (clog2 DIGITS).
  - `cnt`, wide enough for max(REFRESH_DIV, BLANK_CYCLES).
  - `state`.
- FSM states: IDLE, SHOW, BLANK.
  - IDLE → SHOW (idx=0) when `enable`=1.
  - SHOW → BLANK after REFRESH_DIV cycles in SHOW.
  - BLANK → SHOW after BLANK_CYCLES cycles in BLANK. `idx` advances on this transition; idx=DIGITS-1 wraps to 0.
  - Any state → IDLE on the next edge when `enable`=0. This clears `idx` and `cnt`; `pending`, `pend_valid` and `shown` are kept.
- `cnt` clears on every state transition and increments otherwise.
- Load:
  - `load`=1 writes `value_in` into `pending` and sets `pend_valid`.
  - A later load before commit overwrites `pending` (latest wins).
- Commit happens on every edge that enters SHOW with idx=0, from IDLE or from wrap-around, and only if `pend_valid`=1 or `load`=1 in that cycle.
  - The committed word goes into `shown`.
  - If `load`=1 in that cycle, `value_in` is committed directly.
  - `pend_valid` is cleared and `load_ack` pulses on the same edge.
- Output values:
  - In SHOW: `digit_sel_n` = ~(1<<idx), and `segments` = decode of `shown[4idx+3:4idx]` through the shared decoder.
  - In BLANK and IDLE: `digit_sel_n` = all ones and `segments` = 0.
- Nibble values outside 2..9 decode to blank, which is the decoder's existing behaviour. No remapping happens here.

## Timing
- Reset values:
  - State: state=IDLE, idx=0, cnt=0.
  - Buffers: `pending`=0, `pend_valid`=0, `shown`=0.
  - Outputs: `digit_sel_n` all ones, `segments`=0, `frame_start`=0, `load_ack`=0.
- Reset wins over `enable` and `load` in the same cycle.
- Reset in mid-frame darkens the display on that edge.
- All outputs are registered. They change on the same edge the FSM enters the state they describe, with no extra lag.
- Frame period is DIGITS×(REFRESH_DIV+BLANK_CYCLES) cycles.
- `frame_start` pulses on each entry to SHOW with idx=0, together with any commit.
- Load-to-display latency is at most one frame plus one cycle. A load that coincides with the commit edge is visible on that edge.

## Structure
- Shared package holds:
  - segment blank constant `SEG_BLANK` = 7'b0000000;
  - state encodings IDLE, SHOW, BLANK;
  - the `digit_sel_n` all-off constant helper.
- One sub-module: a single instance of the existing `seven_segment`, fed by the mux of `shown` by `idx`. Its output is gated to `SEG_BLANK` outside SHOW before the output register.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
- **Reset and first load.** Stimulus: reset, then `load` with `value_in`=16'h9352, then `enable`=1. Required response:
  - `frame_start` pulses together with `load_ack`.
  - `digit_sel_n` sequence is 1110 / 1111 / 1101 / 1111 / 1011 / 1111 / 0111.
  - `segments` = 1011011, 1101101, 1001111, 1101111.
  - Each digit is lit for exactly 4 cycles; frame period is 20 cycles.
- **No tearing.** Stimulus: load 16'h8888 while digit 2 is lit during a frame showing 16'h9352. Required response:
  - Digits 2 and 3 still show 3 and 9.
  - `load_ack` and all-1111111 segments appear only from the next `frame_start`.
- **Latest wins and coincident load.** Stimulus: two loads in one frame, then a load on the wrap edge. Required response:
  - After the two loads, only the second value is committed, with one `load_ack`.
  - With the load on the wrap edge, `value_in` is shown on that edge.
- **Enable drop mid-frame.** Stimulus: drop `enable` mid-frame, then re-enable. Required response:
  - Next edge: `digit_sel_n`=1111 and `segments`=0.
  - On re-enable, scanning restarts at digit 0 with `frame_start`, and any pending word commits.
- **Blank codes.** Stimulus: `value_in`=16'hF10A. Required response: every digit outputs `segments`=0, while anodes still scan normally.
- **Reset mid-SHOW.** Stimulus: assert `reset` while a digit is in SHOW. Required response:
  - All outputs return to reset values on that edge.
  - `shown` is cleared.

Source files
------------

// File: rtl/display_scanner_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
package display_scanner_pkg;

    // All segments off.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Widest anode bus the all-off helper supports.
    localparam int unsigned MAX_DIGITS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    // Active-low anode pattern with every digit dark; caller truncates to its width.
    function automatic logic [MAX_DIGITS-1:0] anodes_off(input int unsigned digits);
        logic [MAX_DIGITS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/display_scanner_seven_segment.sv
// Hex nibble to seven-segment decoder, bit order {g,f,e,d,c,b,a}, active high.
// Only 2..9 have glyphs; every other code is blank.
module seven_segment (
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    // Pure lookup of the glyph for one nibble.
    always_comb begin
        segments = 7'b0000000;
        case (digit)
            4'd2:    segments = 7'b1011011;
            4'd3:    segments = 7'b1001111;
            4'd4:    segments = 7'b1100110;
            4'd5:    segments = 7'b1101101;
            4'd6:    segments = 7'b1111101;
            4'd7:    segments = 7'b0000111;
            4'd8:    segments = 7'b1111111;
            4'd9:    segments = 7'b1101111;
            default: segments = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment driver: one shared decoder, per-digit dwell,
// blanking gap between digits, and a double-buffered display word that is
// only committed at the start of a frame.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    output logic [DIGITS-1:0]     digit_sel_n,
    output logic [6:0]            segments,
    output logic                  frame_start,
    output logic                  load_ack
);

    localparam int IDX_W   = $clog2(DIGITS);
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF    = DIGITS'(anodes_off(DIGITS));

    scan_state_t           state, state_next;
    logic [IDX_W-1:0]      idx, idx_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [4*DIGITS-1:0]   pending;
    logic                  pend_valid;
    logic [4*DIGITS-1:0]   shown, shown_next;
    logic                  enter_frame;
    logic                  commit;
    logic [3:0]            nibble_next;
    logic [6:0]            seg_decoded;
    logic [6:0]            seg_next;
    logic [DIGITS-1:0]     sel_next;

    // State register, scan position, load buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            pending     <= '0;
            pend_valid  <= 1'b0;
            shown       <= '0;
            digit_sel_n <= SEL_OFF;
            segments    <= SEG_BLANK;
            frame_start <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            cnt         <= cnt_next;
            shown       <= shown_next;
            if (load) pending <= value_in;
            if (commit)    pend_valid <= 1'b0;
            else if (load) pend_valid <= 1'b1;
            digit_sel_n <= sel_next;
            segments    <= seg_next;
            frame_start <= enter_frame;
            load_ack    <= commit;
        end
    end

    // Next-state logic: dwell/blank counting, digit advance, enable override.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        cnt_next    = cnt + CNT_W'(1);
        enter_frame = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            idx_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next  = SHOW;
                    idx_next    = '0;
                    cnt_next    = '0;
                    enter_frame = 1'b1;
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state_next = BLANK;
                        cnt_next   = '0;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_next = SHOW;
                        cnt_next   = '0;
                        if (idx == IDX_LAST) begin
                            idx_next    = '0;
                            enter_frame = 1'b1;
                        end else begin
                            idx_next = idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Frame-boundary commit; a same-cycle load bypasses the pending buffer.
    always_comb begin
        commit     = enter_frame && (pend_valid || load);
        shown_next = shown;
        if (commit) shown_next = load ? value_in : pending;
    end

    // Outputs are computed from next-state values so they register on the
    // same edge that enters the state they describe.
    always_comb begin
        nibble_next = shown_next[4*int'(idx_next) +: 4];
        sel_next    = SEL_OFF;
        seg_next    = SEG_BLANK;
        if (state_next == SHOW) begin
            sel_next = ~(DIGITS'(1) << idx_next);
            seg_next = seg_decoded;
        end
    end

    seven_segment u_decoder (
        .digit    (nibble_next),
        .segments (seg_decoded)
    );

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner with a frame-position reference model.
module tb_display_scanner;

    localparam int DIGITS       = 4;
    localparam int REFRESH_DIV  = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int SLOT         = REFRESH_DIV + BLANK_CYCLES;
    localparam int FRAME        = DIGITS * SLOT;
    localparam logic [12:0] DARK = 13'b1111_0000000_0_0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  digit_sel_n;
    logic [6:0]  segments;
    logic        frame_start;
    logic        load_ack;
    logic [12:0] obs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    display_scanner #(
        .DIGITS       (DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .value_in    (value_in),
        .digit_sel_n (digit_sel_n),
        .segments    (segments),
        .frame_start (frame_start),
        .load_ack    (load_ack)
    );

    assign obs = {digit_sel_n, segments, frame_start, load_ack};

    // Glyphs {g,f,e,d,c,b,a}; only 2..9 are drawn.
    logic [6:0] seg_table [16] = '{7'h00, 7'h00, 7'b1011011, 7'b1001111,
                                   7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                   7'b1111111, 7'b1101111, 7'h00, 7'h00,
                                   7'h00, 7'h00, 7'h00, 7'h00};

    // Reference model: position within the frame since scanning started.
    bit          m_run = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_shown = '0;
    bit          m_pv = 1'b0;
    bit          m_fs = 1'b0;
    bit          m_ack = 1'b0;

    function automatic logic [6:0] glyph(input logic [15:0] word, input int d);
        return seg_table[4'(word >> (4 * d))];
    endfunction

    function automatic logic [12:0] exp_vec();
        logic [3:0] sel;
        logic [6:0] seg;
        sel = 4'hF;
        seg = '0;
        if (m_run && (m_pos % SLOT) < REFRESH_DIV) begin
            sel = ~(4'b0001 << (m_pos / SLOT));
            seg = glyph(m_shown, m_pos / SLOT);
        end
        return {sel, seg, m_fs, m_ack};
    endfunction

    // Advance the model with the inputs present at the coming edge, then clock.
    task automatic step();
        bit at_start;
        at_start = 1'b0;
        m_fs = 1'b0;
        m_ack = 1'b0;
        if (reset) begin
            m_run = 1'b0; m_pos = 0; m_pend = '0; m_pv = 1'b0; m_shown = '0;
        end else begin
            if (!enable) begin
                m_run = 1'b0; m_pos = 0;
            end else if (!m_run) begin
                m_run = 1'b1; m_pos = 0; at_start = 1'b1;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
                at_start = (m_pos == 0);
            end
            m_fs = at_start;
            if (load) m_pend = value_in;
            if (at_start && (load || m_pv)) begin
                m_shown = load ? value_in : m_pend;
                m_pv = 1'b0;
                m_ack = 1'b1;
            end else if (load) begin
                m_pv = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Step until the model sits at frame position pos (scanning must be on).
    task automatic run_to(input int pos);
        int guard;
        guard = 0;
        while (!(m_run && m_pos == pos) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(2, 9));
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; load = 1'b1; value_in = 16'h9352;
        step();
        vectors++;
        if (obs !== DARK) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b", obs, DARK);
        end
        step();
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_hold: got %b want %b", obs, exp_vec());
        end
        load = 1'b0;
    endtask

    task automatic test_first_load();
        logic [3:0] sel_seq [7] = '{4'b1110, 4'b1111, 4'b1101, 4'b1111, 4'b1011, 4'b1111, 4'b0111};
        logic [6:0] seg_seq [4] = '{7'b1011011, 7'b1101101, 7'b1001111, 7'b1101111};
        logic [3:0] sel_q[$];
        logic [6:0] seg_q[$];
        int lit [4];
        int first_fs, second_fs;
        reset = 1'b0; enable = 1'b0; load = 1'b1; value_in = 16'h9352;
        step();
        load = 1'b0; enable = 1'b1;
        lit = '{0, 0, 0, 0};
        first_fs = -1; second_fs = -1;
        for (int c = 0; c < 2 * FRAME + 2; c++) begin
            step();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL first_load_cycle%0d: got %b want %b", c, obs, exp_vec());
            end
            if (frame_start) begin
                if (first_fs < 0) first_fs = c;
                else if (second_fs < 0) second_fs = c;
            end
            if (c < FRAME) begin
                if (sel_q.size() == 0 || sel_q[$] != digit_sel_n) begin
                    sel_q.push_back(digit_sel_n);
                    if (digit_sel_n != 4'hF) seg_q.push_back(segments);
                end
                for (int d = 0; d < 4; d++) if (digit_sel_n == ~(4'b0001 << d)) lit[d]++;
            end
            if (c == 0) begin
                vectors++;
                if ({frame_start, load_ack} !== 2'b11) begin
                    miscompares++;
                    $display("FAIL first_frame_ack: got fs/ack=%b want 11", {frame_start, load_ack});
                end
            end
        end
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (i >= sel_q.size() || sel_q[i] !== sel_seq[i]) begin
                miscompares++;
                $display("FAIL anode_sequence[%0d]: got %b want %b", i,
                         (i < sel_q.size()) ? sel_q[i] : 4'bxxxx, sel_seq[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= seg_q.size() || seg_q[i] !== seg_seq[i]) begin
                miscompares++;
                $display("FAIL segment_sequence[%0d]: got %b want %b", i,
                         (i < seg_q.size()) ? seg_q[i] : 7'bxxxxxxx, seg_seq[i]);
            end
            vectors++;
            if (lit[i] !== REFRESH_DIV) begin
                miscompares++;
                $display("FAIL dwell_digit%0d: got %0d want %0d", i, lit[i], REFRESH_DIV);
            end
        end
        vectors++;
        if (second_fs - first_fs !== FRAME) begin
            miscompares++;
            $display("FAIL frame_period: got %0d want %0d", second_fs - first_fs, FRAME);
        end
    endtask

    task automatic test_no_tearing();
        bit seen_fs;
        int guard;
        run_to(2 * SLOT + 1);
        load = 1'b1; value_in = 16'h8888;
        step();
        load = 1'b0;
        seen_fs = 1'b0;
        guard = 0;
        while (!seen_fs && guard < 2 * FRAME) begin
            step();
            guard++;
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL no_tearing_cycle: got %b want %b", obs, exp_vec());
            end
            if (frame_start) begin
                seen_fs = 1'b1;
                vectors++;
                if ({load_ack, segments} !== {1'b1, 7'b1111111}) begin
                    miscompares++;
                    $display("FAIL new_word_at_frame: got ack=%b seg=%b want 1 1111111", load_ack, segments);
                end
            end else begin
                if (load_ack !== 1'b0) begin
                    miscompares++;
                    $display("FAIL early_ack: got %b want 0", load_ack);
                end
                if (digit_sel_n == 4'b1011 && segments !== 7'b1001111) begin
                    miscompares++;
                    $display("FAIL old_digit2: got %b want 1001111", segments);
                end
                if (digit_sel_n == 4'b0111 && segments !== 7'b1101111) begin
                    miscompares++;
                    $display("FAIL old_digit3: got %b want 1101111", segments);
                end
            end
        end
        vectors++;
        if (!seen_fs) begin
            miscompares++;
            $display("FAIL no_tearing_timeout: got no frame_start want one within %0d cycles", 2 * FRAME);
        end
    endtask

    task automatic test_latest_wins();
        logic [15:0] a, b, c;
        int acks;
        a = rand_word(); b = rand_word(); c = rand_word();
        run_to(3);
        load = 1'b1; value_in = a; step();
        load = 1'b0; step();
        load = 1'b1; value_in = b; step();
        load = 1'b0;
        acks = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL latest_wins_cycle%0d: got %b want %b", i, obs, exp_vec());
            end
            if (load_ack) acks++;
            if (frame_start && segments !== glyph(b, 0)) begin
                miscompares++;
                $display("FAIL latest_value: got %b want %b", segments, glyph(b, 0));
            end
        end
        vectors++;
        if (acks !== 1) begin
            miscompares++;
            $display("FAIL single_ack: got %0d want 1", acks);
        end
        run_to(FRAME - 1);
        load = 1'b1; value_in = c;
        step();
        load = 1'b0;
        vectors++;
        if (obs !== {4'b1110, glyph(c, 0), 2'b11}) begin
            miscompares++;
            $display("FAIL coincident_load: got %b want %b", obs, {4'b1110, glyph(c, 0), 2'b11});
        end
    endtask

    task automatic test_enable_drop();
        logic [15:0] d;
        d = rand_word();
        run_to(7);
        enable = 1'b0;
        step();
        vectors++;
        if (obs !== DARK) begin
            miscompares++;
            $display("FAIL enable_drop_dark: got %b want %b", obs, DARK);
        end
        load = 1'b1; value_in = d; step();
        load = 1'b0; step();
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL idle_hold: got %b want %b", obs, exp_vec());
        end
        enable = 1'b1;
        step();
        vectors++;
        if (obs !== {4'b1110, glyph(d, 0), 2'b11}) begin
            miscompares++;
            $display("FAIL reenable_restart: got %b want %b", obs, {4'b1110, glyph(d, 0), 2'b11});
        end
    endtask

    task automatic test_blank_codes();
        int lit_cycles;
        run_to(FRAME - 3);
        load = 1'b1; value_in = 16'hF10A; step();
        load = 1'b0;
        run_to(FRAME - 1);
        lit_cycles = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            vectors++;
            if (obs !== exp_vec() || segments !== 7'b0) begin
                miscompares++;
                $display("FAIL blank_codes_cycle%0d: got %b want %b", i, obs, exp_vec());
            end
            if (digit_sel_n != 4'hF) lit_cycles++;
        end
        vectors++;
        if (lit_cycles !== DIGITS * REFRESH_DIV) begin
            miscompares++;
            $display("FAIL blank_codes_scan: got %0d lit cycles want %0d", lit_cycles, DIGITS * REFRESH_DIV);
        end
    endtask

    task automatic test_reset_mid_show();
        load = 1'b1; value_in = 16'h9352; step();
        load = 1'b0;
        run_to(SLOT + 2);
        reset = 1'b1;
        step();
        vectors++;
        if (obs !== DARK) begin
            miscompares++;
            $display("FAIL reset_mid_show: got %b want %b", obs, DARK);
        end
        reset = 1'b0;
        for (int i = 0; i < FRAME + 1; i++) begin
            step();
            vectors++;
            if (obs !== exp_vec() || segments !== 7'b0 || load_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL shown_cleared_cycle%0d: got %b want %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            enable   = ($urandom_range(0, 99) != 0);
            load     = ($urandom_range(0, 9) == 0);
            value_in = 16'($urandom);
            step();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %b want %b", i, obs, exp_vec());
            end
        end
        reset = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_no_tearing();
        test_latest_wins();
        test_enable_drop();
        test_blank_codes();
        test_reset_mid_show();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
